mtm_alu_deserializer: RTL and testbench



---
 rtl/mtm_alu_pkg.sv | 39 +++
 rtl/mtm_alu_packet_rx.sv | 80 ++++++++
 rtl/mtm_alu_deserializer.sv | 128 ++++++++++++
 tb/tb_mtm_alu_deserializer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared types, constants and helpers for the mtm_Alu serial front-end.
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    localparam logic PKT_DATA = 1'b0;
    localparam logic PKT_CTL  = 1'b1;

    localparam int unsigned ERR_DATA_BIT = 2;
    localparam int unsigned ERR_CRC_BIT  = 1;
    localparam int unsigned ERR_OP_BIT   = 0;

    localparam int unsigned FRAME_BYTES = 8;

    // CRC-4 (x^4+x+1), init 0, bit 67 processed first
    function automatic logic [3:0] crc4_d68(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    function automatic logic op_is_valid(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mtm_alu_packet_rx.sv
// Bit-level receiver: start, type, 8 payload bits MSB first, stop.
module mtm_alu_packet_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    output logic       pkt_done_c,
    output logic       frame_err_c,
    output logic       rx_idle_c,
    output logic       pkt_type,
    output logic [7:0] pkt_payload
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TYPE      = 3'd1;
    localparam logic [2:0] S_PAYLOAD   = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       type_q, type_d;
    logic [7:0] payload_q, payload_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            type_q    <= 1'b0;
            payload_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            type_q    <= type_d;
            payload_q <= payload_d;
        end
    end

    // Done/error strobes are decoded in the stop-bit cycle so the frame logic can act on the same edge
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        type_d      = type_q;
        payload_d   = payload_q;
        pkt_done_c  = 1'b0;
        frame_err_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!sin) state_d = S_TYPE;
            end
            S_TYPE: begin
                type_d    = sin;
                bit_cnt_d = 3'd0;
                state_d   = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                payload_d = {payload_q[6:0], sin};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = S_STOP;
            end
            S_STOP: begin
                if (sin) begin
                    pkt_done_c = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    frame_err_c = 1'b1;
                    state_d     = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (sin) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rx_idle_c   = (state_q == S_IDLE);
    assign pkt_type    = type_q;
    assign pkt_payload = payload_q;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Frame assembly for mtm_Alu: 8 data bytes + ctl packet -> operands, opcode, error flags.
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] out_b,
    output logic [31:0] out_a,
    output logic [2:0]  out_op,
    output logic [2:0]  out_err
);

    localparam int unsigned TMR_W = $clog2(IDLE_TIMEOUT + 1);

    logic       pkt_done_c, frame_err_c, rx_idle_c, pkt_type;
    logic [7:0] pkt_payload;

    mtm_alu_packet_rx u_rx (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .pkt_done_c (pkt_done_c),
        .frame_err_c(frame_err_c),
        .rx_idle_c  (rx_idle_c),
        .pkt_type   (pkt_type),
        .pkt_payload(pkt_payload)
    );

    logic [3:0]       byte_cnt_q, byte_cnt_d;
    logic [63:0]      shreg_q, shreg_d;
    logic [TMR_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_b_q, out_b_d, out_a_q, out_a_d;
    logic [2:0]       out_op_q, out_op_d, out_err_q, out_err_d;

    logic       complete_c, err_data_c, err_crc_c, err_op_c, cnt_full_c;
    logic [3:0] crc_calc_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q  <= 4'd0;
            shreg_q     <= 64'd0;
            idle_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_b_q     <= 32'd0;
            out_a_q     <= 32'd0;
            out_op_q    <= 3'd0;
            out_err_q   <= 3'd0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            shreg_q     <= shreg_d;
            idle_cnt_q  <= idle_cnt_d;
            out_valid_q <= out_valid_d;
            out_b_q     <= out_b_d;
            out_a_q     <= out_a_d;
            out_op_q    <= out_op_d;
            out_err_q   <= out_err_d;
        end
    end

    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        shreg_d     = shreg_q;
        idle_cnt_d  = '0;
        out_valid_d = 1'b0;
        out_b_d     = out_b_q;
        out_a_d     = out_a_q;
        out_op_d    = out_op_q;
        out_err_d   = out_err_q;
        complete_c  = 1'b0;
        err_data_c  = 1'b0;
        cnt_full_c  = (byte_cnt_q == 4'(FRAME_BYTES));
        crc_calc_c  = crc4_d68({shreg_q, 1'b1, pkt_payload[6:4]});

        // Partial frame abandoned after a long idle gap
        if (byte_cnt_q != 4'd0 && rx_idle_c) begin
            if (idle_cnt_q == TMR_W'(IDLE_TIMEOUT - 1)) begin
                byte_cnt_d = 4'd0;
                shreg_d    = 64'd0;
            end else begin
                idle_cnt_d = idle_cnt_q + TMR_W'(1);
            end
        end

        if (frame_err_c) begin
            complete_c = 1'b1;
            err_data_c = 1'b1;
        end else if (pkt_done_c) begin
            if (pkt_type == PKT_CTL) begin
                complete_c = 1'b1;
                err_data_c = !cnt_full_c;
            end else if (cnt_full_c) begin
                complete_c = 1'b1;
                err_data_c = 1'b1;
            end else begin
                shreg_d    = {shreg_q[55:0], pkt_payload};
                byte_cnt_d = byte_cnt_q + 4'd1;
            end
        end

        err_crc_c = complete_c && !err_data_c && (crc_calc_c != pkt_payload[3:0]);
        err_op_c  = complete_c && !err_data_c && !err_crc_c && !op_is_valid(pkt_payload[6:4]);

        if (complete_c) begin
            out_valid_d            = 1'b1;
            out_b_d                = shreg_q[63:32];
            out_a_d                = shreg_q[31:0];
            out_op_d               = pkt_payload[6:4];
            out_err_d[ERR_DATA_BIT] = err_data_c;
            out_err_d[ERR_CRC_BIT]  = err_crc_c;
            out_err_d[ERR_OP_BIT]   = err_op_c;
            byte_cnt_d             = 4'd0;
            shreg_d                = 64'd0;
            idle_cnt_d             = '0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_b     = out_b_q;
    assign out_a     = out_a_q;
    assign out_op    = out_op_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for mtm_alu_deserializer: frame vectors plus timeout, framing and reset sequences.
module tb_mtm_alu_deserializer;

    localparam int unsigned IDLE_TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic        out_valid;
    logic [31:0] out_b, out_a;
    logic [2:0]  out_op, out_err;

    mtm_alu_deserializer #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .out_valid(out_valid),
        .out_b    (out_b),
        .out_a    (out_a),
        .out_op   (out_op),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
        logic [3:0]  crc;
        logic        model_crc;
        int          n_data;
        logic        send_ctl;
        logic [2:0]  exp_err;
        logic [31:0] exp_b;
        logic [31:0] exp_a;
        logic        chk_op;
    } vec_t;

    vec_t vecs[9];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_valid = 0;
    int valid_cyc = 0;
    int start_cyc = 0;

    // Pulse counter sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (out_valid === 1'b1) begin
            n_valid++;
            valid_cyc = cyc;
        end
    end

    // Remainder of M(x)*x^4 divided by x^4+x+1
    function automatic logic [3:0] ref_crc(input logic [67:0] d);
        logic [71:0] r;
        r = {d, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        @(negedge clk);
    endtask

    task automatic send_pkt(input logic t, input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_bit(t);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_bytes(input logic [63:0] ba, input int first, input int last);
        for (int i = first; i < last; i++) begin
            if (i < 8) send_pkt(1'b0, ba[63-8*i -: 8], 1'b1);
            else       send_pkt(1'b0, 8'hAA, 1'b1);
        end
    endtask

    task automatic check_outputs(input string tag, input int v0, input logic [2:0] err,
                                 input logic [31:0] b, input logic [31:0] a);
        check({tag, "/valid_cnt"}, 32'(n_valid - v0), 32'd1);
        check({tag, "/err"},  32'(out_err), 32'(err));
        check({tag, "/b"},    out_b, b);
        check({tag, "/a"},    out_a, a);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [3:0] crc;
        int         v0;
        int         n_pkts;
        crc    = v.model_crc ? ref_crc({v.b, v.a, 1'b1, v.op}) : v.crc;
        n_pkts = v.n_data + (v.send_ctl ? 1 : 0);
        v0        = n_valid;
        start_cyc = cyc;
        send_bytes({v.b, v.a}, 0, v.n_data);
        if (v.send_ctl) send_pkt(1'b1, {1'b0, v.op, crc}, 1'b1);
        idle(4);
        check_outputs(tag, v0, v.exp_err, v.exp_b, v.exp_a);
        // out_valid rises in the cycle right after the last stop bit
        check({tag, "/latency"}, 32'(valid_cyc - start_cyc), 32'(11 * n_pkts));
        if (v.chk_op) check({tag, "/op"}, 32'(out_op), 32'(v.op));
    endtask

    initial begin
        int          v0;
        logic [63:0] ba1;
        logic [3:0]  crc1;

        vecs[0] = '{32'h0, 32'h0, 3'b000, 4'b1011, 1'b0, 8, 1'b1, 3'b000, 32'h0, 32'h0, 1'b1};
        vecs[1] = '{32'h11223344, 32'h55667788, 3'b100, 4'h0, 1'b1, 8, 1'b1, 3'b000,
                    32'h11223344, 32'h55667788, 1'b1};
        vecs[2] = '{32'h0, 32'h0, 3'b000, 4'b0000, 1'b0, 8, 1'b1, 3'b010, 32'h0, 32'h0, 1'b1};
        vecs[3] = '{32'h0, 32'h0, 3'b010, 4'b1101, 1'b0, 8, 1'b1, 3'b001, 32'h0, 32'h0, 1'b1};
        vecs[4] = '{32'h11223344, 32'h55667788, 3'b100, 4'h0, 1'b0, 7, 1'b1, 3'b100,
                    32'h00112233, 32'h44556677, 1'b0};
        vecs[5] = '{32'hDEADBEEF, 32'h01234567, 3'b101, 4'h0, 1'b1, 8, 1'b1, 3'b000,
                    32'hDEADBEEF, 32'h01234567, 1'b1};
        vecs[6] = '{32'hFFFFFFFF, 32'h0, 3'b001, 4'h0, 1'b1, 8, 1'b1, 3'b000,
                    32'hFFFFFFFF, 32'h0, 1'b1};
        vecs[7] = '{32'hCAFEF00D, 32'h12345678, 3'b111, 4'h0, 1'b1, 8, 1'b1, 3'b001,
                    32'hCAFEF00D, 32'h12345678, 1'b1};
        vecs[8] = '{32'h0A0B0C0D, 32'h01020304, 3'b000, 4'h0, 1'b0, 9, 1'b0, 3'b100,
                    32'h0A0B0C0D, 32'h01020304, 1'b0};

        ba1  = {32'h11223344, 32'h55667788};
        crc1 = ref_crc({ba1, 1'b1, 3'b100});

        rst = 1'b1;
        sin = 1'b1;
        @(negedge clk);
        idle(3);
        rst = 1'b0;
        check("reset/valid", 32'(out_valid), 32'd0);
        check("reset/b",     out_b, 32'd0);
        check("reset/a",     out_a, 32'd0);
        check("reset/op",    32'(out_op), 32'd0);
        check("reset/err",   32'(out_err), 32'd0);
        idle(3);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Bad stop bit on packet 3, line then held low: must wait for high before rearming
        v0 = n_valid;
        send_pkt(1'b0, 8'hC3, 1'b1);
        send_pkt(1'b0, 8'h5A, 1'b1);
        send_pkt(1'b0, 8'h77, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        idle(4);
        check_outputs("framing", v0, 3'b100, 32'h0, 32'h0000C35A);
        run_vec(vecs[1], "after_framing");

        // Gap just short of the timeout keeps the partial frame
        v0 = n_valid;
        send_bytes(ba1, 0, 4);
        idle(IDLE_TIMEOUT - 2);
        send_bytes(ba1, 4, 8);
        send_pkt(1'b1, {1'b0, 3'b100, crc1}, 1'b1);
        idle(4);
        check_outputs("gap_short", v0, 3'b000, 32'h11223344, 32'h55667788);

        // Gap beyond the timeout discards the partial frame silently
        v0 = n_valid;
        send_bytes({32'hA5A5A5A5, 32'h5A5A5A5A}, 0, 4);
        idle(IDLE_TIMEOUT + 4);
        check("timeout/no_valid", 32'(n_valid - v0), 32'd0);
        run_vec(vecs[1], "after_timeout");

        // Reset at bit 50 of a frame, after outputs were loaded with non-zero data
        run_vec(vecs[5], "pre_reset");
        v0 = n_valid;
        send_bytes(ba1, 0, 4);
        send_bit(1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        send_bit(1'b1);
        rst = 1'b0;
        idle(150);
        check("midreset/no_valid", 32'(n_valid - v0), 32'd0);
        check("midreset/valid",    32'(out_valid), 32'd0);
        check("midreset/b",        out_b, 32'd0);
        check("midreset/a",        out_a, 32'd0);
        check("midreset/op",       32'(out_op), 32'd0);
        check("midreset/err",      32'(out_err), 32'd0);
        run_vec(vecs[1], "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
